mem_responder: RTL and testbench



---
 rtl/cpu_mem_pkg.sv | 7 +
 rtl/mem_array.sv | 22 ++
 rtl/mem_responder.sv | 102 ++++++++++
 tb/tb_mem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared state encoding and default sizes for the CPU memory responder.
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} mem_state_t;
  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_WAIT_DEFAULT = 2;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous word store with write enable and registered read.
module mem_array
  import cpu_mem_pkg::*;
#(
  parameter int AW = MEM_ADDR_W,
  parameter int W = MEM_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata_q
);
  logic [W-1:0] mem [2**AW];
  // Contents are never reset, but a write coinciding with reset is dropped.
  always_ff @(posedge clk)
    if (en && we && !rst) mem[addr] <= wdata;
  always_ff @(posedge clk)
    rdata_q <= rst ? '0 : (en && !we) ? mem[addr] : rdata_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: ReadRAM/WriteRAM servicing FSM with wait states over mem_array.
// Optional MEM_PARITY_EN stores an even-parity bit per word and reports ParityErr on reads.
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int WAIT_STATES = MEM_WAIT_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReadRAM,
  input  logic              WriteRAM,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Busy,
  output logic              Error,
  output logic              ParityErr
);
`ifdef MEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  mem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic is_wr_q, is_wr_d, rd_prev_q, wr_prev_q;
  logic done_q, done_d, busy_q, busy_d, error_q, error_d;
  logic rd_rise, wr_rise, illegal, accept;
  logic [MW-1:0] wdata_m, rdata;
  always_comb begin
    rd_rise = ReadRAM && !rd_prev_q;
    wr_rise = WriteRAM && !wr_prev_q;
    illegal = (rd_rise && WriteRAM) || (wr_rise && ReadRAM);
    accept = state_q == IDLE && (rd_rise || wr_rise) && !illegal;
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = accept ? Address : addr_q;
    wdata_d = accept ? DataIn : wdata_q;
    is_wr_d = accept ? wr_rise : is_wr_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = WAIT_STATES == 0 ? ACCESS : WAIT;
        cnt_d = 4'(WAIT_STATES);
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? ACCESS : WAIT;
      end
      ACCESS: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = state_d == DONE;
    busy_d = state_d != IDLE;
    error_d = state_q == IDLE && illegal;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rd_prev_q <= ReadRAM;
      wr_prev_q <= WriteRAM;
      done_q <= done_d;
      busy_q <= busy_d;
      error_q <= error_d;
    end
  end
`ifdef MEM_PARITY_EN
  assign wdata_m = {^wdata_q, wdata_q};
  assign ParityErr = ^rdata;
`else
  assign wdata_m = wdata_q;
  assign ParityErr = 1'b0;
`endif
  mem_array #(.AW(ADDR_W), .W(MW)) u_array (
    .clk(Clock), .rst(Reset), .en(state_q == ACCESS), .we(is_wr_q),
    .addr(addr_q), .wdata(wdata_m), .rdata_q(rdata)
  );
  assign DataOut = rdata[DATA_W-1:0];
  assign Done = done_q;
  assign Busy = busy_q;
  assign Error = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench; instance 0 has 2 wait states, instance 1 has none.
module tb_mem_responder;
  logic clk = 1'b0, rst;
  logic [1:0] rd, wr, done, busy, err, perr;
  logic [8:0] addr;
  logic [31:0] din;
  logic [31:0] dout [2];
  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  int n_asrt = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(2)) dut (
    .Clock(clk), .Reset(rst), .ReadRAM(rd[0]), .WriteRAM(wr[0]), .Address(addr), .DataIn(din),
    .DataOut(dout[0]), .Done(done[0]), .Busy(busy[0]), .Error(err[0]), .ParityErr(perr[0])
  );
  mem_responder #(.WAIT_STATES(0)) dut0 (
    .Clock(clk), .Reset(rst), .ReadRAM(rd[1]), .WriteRAM(wr[1]), .Address(addr), .DataIn(din),
    .DataOut(dout[1]), .Done(done[1]), .Busy(busy[1]), .Error(err[1]), .ParityErr(perr[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input int s, input bit w, input logic [8:0] a, input logic [31:0] d,
                        input int exp_lat, input logic exp_pe);
    int lat, bc;
    logic [31:0] e;
    @(negedge clk);
    addr = a;
    din = d;
    if (w) begin
      wr[s] = 1'b1;
      model[s * 1024 + int'(a)] = d;
    end else begin
      rd[s] = 1'b1;
      exp_q.push_back(model[s * 1024 + int'(a)]);
    end
    lat = 0;
    bc = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      bc += int'(busy[s]);
      if (done[s]) lat = i;
    end
    rd[s] = 1'b0;
    wr[s] = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_cycles", 32'(bc), 32'(exp_lat));
    if (!w) begin
      e = exp_q.pop_front();
      chk("rdata", dout[s], e);
      chk("parity", {31'b0, perr[s]}, {31'b0, exp_pe});
    end
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done[s]}, 32'b0);
    chk("busy_idle", {31'b0, busy[s]}, 32'b0);
  endtask

  initial begin
    int n;
    logic [31:0] e;
    rst = 1'b1;
    rd = '0;
    wr = '0;
    addr = '0;
    din = '0;
    repeat (2) @(negedge clk);
    chk("rst_dataout", dout[0], 32'h0);
    chk("rst_done", {31'b0, done[0]}, 32'h0);
    chk("rst_busy", {31'b0, busy[0]}, 32'h0);
    chk("rst_error", {31'b0, err[0]}, 32'h0);
    chk("rst_parity", {31'b0, perr[0]}, 32'h0);
    rst = 1'b0;

    access(0, 1'b1, 9'h055, 32'hDEADBEEF, 4, 1'b0);
    access(0, 1'b0, 9'h055, 32'h0, 4, 1'b0);
    access(0, 1'b1, 9'h1FF, 32'hA5A5A5A5, 4, 1'b0);
    access(0, 1'b1, 9'h000, 32'h0F0F1234, 4, 1'b0);
    access(0, 1'b0, 9'h1FF, 32'h0, 4, 1'b0);
    access(0, 1'b0, 9'h000, 32'h0, 4, 1'b0);

    // Both strobes rising together must flag Error and make no access.
    @(negedge clk);
    addr = 9'h055;
    din = 32'h11111111;
    rd[0] = 1'b1;
    wr[0] = 1'b1;
    @(negedge clk);
    chk("illegal_error", {31'b0, err[0]}, 32'h1);
    chk("illegal_busy", {31'b0, busy[0]}, 32'h0);
    rd[0] = 1'b0;
    wr[0] = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(done[0]) + int'(busy[0]);
    end
    chk("illegal_no_done", 32'(n), 32'h0);
    chk("illegal_error_pulse", {31'b0, err[0]}, 32'h0);
    access(0, 1'b0, 9'h055, 32'h0, 4, 1'b0);

    // Held read strobe: serviced once only.
    @(negedge clk);
    addr = 9'h1FF;
    rd[0] = 1'b1;
    exp_q.push_back(model[9'h1FF]);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done[0]) begin
        n++;
        e = exp_q.pop_front();
        chk("held_rd_data", dout[0], e);
      end
    end
    rd[0] = 1'b0;
    chk("held_rd_count", 32'(n), 32'h1);

    // Held write strobe with data changing after Done: only the first value lands.
    @(negedge clk);
    addr = 9'h100;
    din = 32'hCAFEF00D;
    wr[0] = 1'b1;
    model[9'h100] = 32'hCAFEF00D;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done[0]) begin
        n++;
        din = 32'h0BADC0DE;
      end
    end
    wr[0] = 1'b0;
    chk("held_wr_count", 32'(n), 32'h1);
    access(0, 1'b0, 9'h100, 32'h0, 4, 1'b0);

    // Reset while a write is in WAIT: write lost, outputs cleared.
    @(negedge clk);
    addr = 9'h1FF;
    din = 32'h12345678;
    wr[0] = 1'b1;
    @(negedge clk);
    chk("midwr_busy", {31'b0, busy[0]}, 32'h1);
    rst = 1'b1;
    wr[0] = 1'b0;
    @(negedge clk);
    chk("midrst_dataout", dout[0], 32'h0);
    chk("midrst_done", {31'b0, done[0]}, 32'h0);
    chk("midrst_busy", {31'b0, busy[0]}, 32'h0);
    chk("midrst_error", {31'b0, err[0]}, 32'h0);
    chk("midrst_parity", {31'b0, perr[0]}, 32'h0);
    rst = 1'b0;
    access(0, 1'b0, 9'h1FF, 32'h0, 4, 1'b0);

    // Zero wait states.
    access(1, 1'b1, 9'h000, 32'h13579BDF, 2, 1'b0);
    access(1, 1'b0, 9'h000, 32'h0, 2, 1'b0);

`ifdef MEM_PARITY_EN
    access(0, 1'b1, 9'h0AA, 32'h00000001, 4, 1'b0);
    dut.u_array.mem[9'h0AA][0] = ~dut.u_array.mem[9'h0AA][0];
    model[9'h0AA] = 32'h0;
    access(0, 1'b0, 9'h0AA, 32'h0, 4, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
